serial_borrow_subtractor: RTL and testbench

//  Bit-serial A - B - Bin subtractor. Reuses one 1-bit full-subtractor cell and a borrow flop over WIDTH cycles.

---
 rtl/sub_pkg.sv | 11 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_borrow_subtractor.sv | 88 ++++++++
 tb/tb_serial_borrow_subtractor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial borrow subtractor.
// Holds the FSM state encoding used by the top level.
package sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; the serial top reuses a single instance every cycle.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial A - B - Bin subtractor with valid/ready handshakes on both sides.
// One bit per cycle, LSB first, through a shared full-subtractor cell and a borrow flop.
module serial_borrow_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             borrow;
   logic             d_bit;
   logic             br_next;

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (d_bit),
      .bout (br_next)
   );

   // Handshake flags are decodes of the state register, so they never glitch on inputs.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign bout      = borrow;

   always_ff @(posedge clk) begin
      // NOTE: all state is updated with non-blocking assignments so every register
      // sees the pre-edge values of the others (shift regs and borrow move together).
      if (rst) begin
         state  <= S_IDLE;
         count  <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= bin;
                  count  <= '0;
                  state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               diff   <= {d_bit, diff[WIDTH-1:1]};
               borrow <= br_next;
               // count parks at the last index so it never leaves 0..WIDTH-1.
               if (count == LAST) begin
                  state <= S_DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor: vector table, corner sequences,
// random operands against an arithmetic model, and an exhaustive WIDTH=4 sweep.
module tb_serial_borrow_subtractor;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
   logic [7:0] a, b, diff;
   logic       in_valid4, in_ready4, out_valid4, out_ready4, bin4, bout4;
   logic [3:0] a4, b4, diff4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   vec_t vecs [8];

   serial_borrow_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout)
   );

   serial_borrow_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .bout(bout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: {bout, diff} from plain signed arithmetic on a w-bit problem.
   function automatic logic [8:0] ref_sub(input int w, input int av, input int bv, input int bi);
      int r;
      r = av - bv - bi;
      return {(r < 0) ? 1'b1 : 1'b0, 8'(r & ((1 << w) - 1))};
   endfunction

   task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                      input logic bi, input logic [7:0] ed, input logic eb, input int hold);
      int lat;
      @(negedge clk);
      check({name, "/in_ready"}, 32'(in_ready), 1);
      a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, "/latency"}, 32'(lat), 8);
      check({name, "/diff"}, 32'(diff), 32'(ed));
      check({name, "/bout"}, 32'(bout), 32'(eb));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         @(negedge clk);
         check({name, "/hold_valid"}, 32'(out_valid), 1);
         check({name, "/hold_in_ready"}, 32'(in_ready), 0);
         check({name, "/hold_diff"}, 32'(diff), 32'(ed));
         check({name, "/hold_bout"}, 32'(bout), 32'(eb));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "/retired"}, 32'(out_valid), 0);
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
      int lat;
      logic [8:0] e;
      e = ref_sub(4, int'(av), int'(bv), int'(bi));
      @(negedge clk);
      a4 = av; b4 = bv; bin4 = bi; in_valid4 = 1'b1; out_ready4 = 1'b0;
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (out_valid4 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("w4 %0h-%0h-%0h latency", av, bv, bi), 32'(lat), 4);
      check($sformatf("w4 %0h-%0h-%0h result", av, bv, bi), {27'd0, bout4, diff4},
            {27'd0, e[8], e[3:0]});
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rbi;
      logic [8:0] e;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'h01, 8'hFF, 1'b0, 8'h02, 1'b1};
      vecs[7] = '{8'hC3, 8'h42, 1'b1, 8'h80, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset/in_ready", 32'(in_ready), 1);
      check("reset/out_valid", 32'(out_valid), 0);
      check("reset/diff", 32'(diff), 0);
      check("reset/bout", 32'(bout), 0);

      for (int i = 0; i < 8; i++) begin
         op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].diff, vecs[i].bout, 0);
      end

      // Backpressure: result must stay frozen while the consumer stalls.
      op8("backpressure", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 5);

      // Reset in the middle of a BUSY pass (count == 3).
      @(negedge clk);
      a = 8'hA5; b = 8'h17; bin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midbusy/in_ready", 32'(in_ready), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset/in_ready", 32'(in_ready), 1);
      check("midreset/out_valid", 32'(out_valid), 0);
      check("midreset/diff", 32'(diff), 0);
      check("midreset/bout", 32'(bout), 0);
      op8("after_reset", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 0);

      for (int i = 0; i < 25; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rbi = 1'($urandom);
         e   = ref_sub(8, int'(ra), int'(rb), int'(rbi));
         op8($sformatf("rand%0d", i), ra, rb, rbi, e[7:0], e[8], int'($urandom_range(0, 2)));
      end

      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               op4(4'(ia), 4'(ib), 1'(ic));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
